// File: rtl/vector_minmax_reduction_unit_if.sv
// -----------------------------------------------------------------------------
// vector_minmax_reduction_unit_if
// Handshake bundle for the min/max reduction stage.
//   beat_valid / beat_ready / beat_data : element-group beats from the VRF read path
//   beat_mask                           : per-element mask (only with MINMAX_RED_MASK_EN)
//   result_valid / result_ready / result: scalar result towards writeback
// Modports:
//   slave  : the reduction unit (consumes beats, produces the result)
//   master : the surrounding pipeline (produces beats, consumes the result)
// Optional macro: MINMAX_RED_MASK_EN adds beat_mask[7:0].
// -----------------------------------------------------------------------------
interface vector_minmax_reduction_unit_if;
    logic        beat_valid;
    logic        beat_ready;
    logic [63:0] beat_data;
`ifdef MINMAX_RED_MASK_EN
    logic [7:0]  beat_mask;
`endif
    logic        result_valid;
    logic        result_ready;
    logic [63:0] result;

    modport slave (
        input  beat_valid,
        input  beat_data,
        output beat_ready,
`ifdef MINMAX_RED_MASK_EN
        input  beat_mask,
`endif
        output result_valid,
        output result,
        input  result_ready
    );

    modport master (
        output beat_valid,
        output beat_data,
        input  beat_ready,
`ifdef MINMAX_RED_MASK_EN
        output beat_mask,
`endif
        input  result_valid,
        input  result,
        output result_ready
    );
endinterface

// File: rtl/vector_minmax_reduction_unit.sv
// -----------------------------------------------------------------------------
// vector_minmax_reduction_unit
// Sequential reduction for vredmin/vredminu/vredmax/vredmaxu. Beats are folded
// lane-wise into a 64-bit accumulator, the accumulator is tree-reduced to one
// SEW-wide element, and that element is combined with vs1[0].
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a reduction (honoured only when idle)
//   op, sew, vl      : operation, element width code, active element count
//   scalar_in        : vs1[0]; low SEW bits used
//   flush            : synchronous abort
//   busy             : unit is not idle
//   bus (slave)      : beat input and result output handshakes
// Optional macro: MINMAX_RED_MASK_EN enables per-element beat masking.
//
// state  | meaning
// IDLE   | waiting for start
// ACCUM  | accepting beats, lane-wise fold into accumulator
// FOLD   | halving the accumulator, one step per cycle
// FINAL  | combine reduced element with the scalar operand
// DONE   | result presented until accepted
// -----------------------------------------------------------------------------
module vector_minmax_reduction_unit #(
    parameter int ELEN     = 64,
    parameter int VL_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [1:0]              sew,
    input  logic [VL_WIDTH-1:0]     vl,
    input  logic [ELEN-1:0]         scalar_in,
    input  logic                    flush,
    output logic                    busy,
    vector_minmax_reduction_unit_if.slave bus
);

    localparam int LW = VL_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FOLD, S_FINAL, S_DONE} state_t;

    // op[0]: unsigned compare, op[1]: max instead of min
    function automatic logic [ELEN-1:0] lane_op(input logic [ELEN-1:0] a,
                                                input logic [ELEN-1:0] b,
                                                input logic [1:0]      o,
                                                input logic [1:0]      s);
        logic [ELEN-1:0] r;
        logic            lt;
        r = '0;
        case (s)
            2'd0: for (int i = 0; i < 8; i++) begin
                lt = o[0] ? (a[i*8 +: 8] < b[i*8 +: 8])
                          : ($signed(a[i*8 +: 8]) < $signed(b[i*8 +: 8]));
                r[i*8 +: 8] = (lt ^ o[1]) ? a[i*8 +: 8] : b[i*8 +: 8];
            end
            2'd1: for (int i = 0; i < 4; i++) begin
                lt = o[0] ? (a[i*16 +: 16] < b[i*16 +: 16])
                          : ($signed(a[i*16 +: 16]) < $signed(b[i*16 +: 16]));
                r[i*16 +: 16] = (lt ^ o[1]) ? a[i*16 +: 16] : b[i*16 +: 16];
            end
            2'd2: for (int i = 0; i < 2; i++) begin
                lt = o[0] ? (a[i*32 +: 32] < b[i*32 +: 32])
                          : ($signed(a[i*32 +: 32]) < $signed(b[i*32 +: 32]));
                r[i*32 +: 32] = (lt ^ o[1]) ? a[i*32 +: 32] : b[i*32 +: 32];
            end
            default: begin
                lt = o[0] ? (a < b) : ($signed(a) < $signed(b));
                r  = (lt ^ o[1]) ? a : b;
            end
        endcase
        return r;
    endfunction

    // Identity lane: MSB set for minu/max, remaining bits set for the min ops.
    function automatic logic [ELEN-1:0] ident(input logic [1:0] o, input logic [1:0] s);
        logic msb;
        logic rest;
        msb  = o[0] ^ o[1];
        rest = ~o[1];
        case (s)
            2'd0:    return {8{msb, {7{rest}}}};
            2'd1:    return {4{msb, {15{rest}}}};
            2'd2:    return {2{msb, {31{rest}}}};
            default: return {msb, {63{rest}}};
        endcase
    endfunction

    function automatic logic [ELEN-1:0] sew_mask(input logic [1:0] s);
        case (s)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return '1;
        endcase
    endfunction

    state_t            state_q;
    logic [1:0]        op_q, sew_q, fold_cnt_q;
    logic [VL_WIDTH-1:0] vl_q;
    logic [ELEN-1:0]   scalar_q, acc_q, result_q;
    logic              result_valid_q;
    logic [LW-1:0]     beats_left_q, elem_base_q;

    logic [3:0]        lanes_in, lanes_q;
    logic [LW-1:0]     beats_init_d;
    logic [7:0]        lane_act;
    logic [ELEN-1:0]   bit_act, beat_eff, acc_accum_d, acc_fold_d, result_d;
    logic [ELEN-1:0]   fold_lo, fold_hi;
    logic [1:0]        fold_w;

    assign lanes_in     = 4'd8 >> sew;
    assign lanes_q      = 4'd8 >> sew_q;
    assign beats_init_d = ({1'b0, vl} + LW'(lanes_in - 4'd1)) >> (2'd3 - sew);

    // Tail elements (and masked elements) are swapped for the identity so
    // they can never win the compare.
    always_comb begin
        lane_act = '0;
        for (int i = 0; i < 8; i++) begin
            lane_act[i] = (({1'b0, elem_base_q} + (LW+1)'(i)) < (LW+1)'(vl_q));
`ifdef MINMAX_RED_MASK_EN
            lane_act[i] = lane_act[i] & bus.beat_mask[i];
`endif
        end
        bit_act = '0;
        for (int b = 0; b < 8; b++) begin
            bit_act[b*8 +: 8] = {8{lane_act[3'(b) >> sew_q]}};
        end
    end

    assign beat_eff    = (bus.beat_data & bit_act) | (ident(op_q, sew_q) & ~bit_act);
    assign acc_accum_d = lane_op(acc_q, beat_eff, op_q, sew_q);

    // Current accumulator width code: 3=64, 2=32, 1=16 bits still live.
    assign fold_w = sew_q + fold_cnt_q;

    always_comb begin
        fold_lo = acc_q;
        fold_hi = acc_q;
        case (fold_w)
            2'd3: begin
                fold_lo = {32'b0, acc_q[31:0]};
                fold_hi = {32'b0, acc_q[63:32]};
            end
            2'd2: begin
                fold_lo = {48'b0, acc_q[15:0]};
                fold_hi = {48'b0, acc_q[31:16]};
            end
            2'd1: begin
                fold_lo = {56'b0, acc_q[7:0]};
                fold_hi = {56'b0, acc_q[15:8]};
            end
            default: ;
        endcase
    end

    assign acc_fold_d = lane_op(fold_lo, fold_hi, op_q, sew_q);
    assign result_d   = lane_op(acc_q, scalar_q, op_q, sew_q) & sew_mask(sew_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            sew_q          <= '0;
            vl_q           <= '0;
            scalar_q       <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            beats_left_q   <= '0;
            elem_base_q    <= '0;
            fold_cnt_q     <= '0;
        end else if (flush && state_q != S_IDLE) begin
            state_q        <= S_IDLE;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q         <= op;
                        sew_q        <= sew;
                        vl_q         <= vl;
                        scalar_q     <= scalar_in & sew_mask(sew);
                        acc_q        <= ident(op, sew);
                        beats_left_q <= beats_init_d;
                        elem_base_q  <= '0;
                        state_q      <= (vl != '0) ? S_ACCUM : S_FINAL;
                    end
                end
                S_ACCUM: begin
                    if (bus.beat_valid) begin
                        acc_q        <= acc_accum_d;
                        beats_left_q <= beats_left_q - LW'(1);
                        elem_base_q  <= elem_base_q + LW'(lanes_q);
                        if (beats_left_q == LW'(1)) begin
                            fold_cnt_q <= 2'd3 - sew_q;
                            state_q    <= (sew_q == 2'd3) ? S_FINAL : S_FOLD;
                        end
                    end
                end
                S_FOLD: begin
                    acc_q      <= acc_fold_d;
                    fold_cnt_q <= fold_cnt_q - 2'd1;
                    if (fold_cnt_q == 2'd1) state_q <= S_FINAL;
                end
                S_FINAL: begin
                    result_q       <= result_d;
                    result_valid_q <= 1'b1;
                    state_q        <= S_DONE;
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign bus.beat_ready   = (state_q == S_ACCUM) && !flush;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;

endmodule
